// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage stall/flush controller for load-use, ID-branch and mul/div hazards
// All outputs are combinational from the two counters and the current ID/EX/MEM inputs.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_reg,
    input  logic [4:0] rt_reg,
    input  logic       UseRs_ID,
    input  logic       UseRt_ID,
    input  logic       Branch_ID,
    input  logic       Taken_ID,
    input  logic       MulDiv_ID,
    input  logic       HiLoRd_ID,
    input  logic [4:0] rw_IDEx,
    input  logic       RegWr_IDEx,
    input  logic       MemRead_IDEx,
    input  logic [4:0] rw_ExMem,
    input  logic       MemRead_ExMem,
    output logic       PCWr,
    output logic       IFIDWr,
    output logic       IDEx_Flush,
    output logic       IFID_Flush,
    output logic       MulDivBusy
);

    localparam logic [3:0] LAT = 4'(MULDIV_LAT);

    logic [1:0] hcnt_q, hcnt_d;
    logic [3:0] mcnt_q, mcnt_d;

    logic       match_e;
    logic       match_m;
    logic [1:0] need_n;
    logic       mul_wait;
    logic       stall;

    always_comb begin
        match_e = RegWr_IDEx && (rw_IDEx != 5'd0) &&
                  ((UseRs_ID && (rw_IDEx == rs_reg)) || (UseRt_ID && (rw_IDEx == rt_reg)));
        match_m = MemRead_ExMem && (rw_ExMem != 5'd0) &&
                  ((UseRs_ID && (rw_ExMem == rs_reg)) || (UseRt_ID && (rw_ExMem == rt_reg)));
    end

    // Stall depth for a freshly detected hazard; a branch compared in ID needs
    // its operand one stage earlier than an ALU consumer does.
    always_comb begin
        need_n = 2'd0;
        if (Branch_ID && match_e && MemRead_IDEx) begin
            need_n = 2'd2;
        end else if (Branch_ID && (match_e || match_m)) begin
            need_n = 2'd1;
        end else if (!Branch_ID && match_e && MemRead_IDEx) begin
            need_n = 2'd1;
        end
    end

    always_comb begin
        mul_wait = (MulDiv_ID || HiLoRd_ID) && (mcnt_q != 4'd0);
        hcnt_d   = 2'd0;
        stall    = 1'b0;
        if (hcnt_q != 2'd0) begin
            stall  = 1'b1;
            hcnt_d = hcnt_q - 2'd1;
        end else if (need_n != 2'd0) begin
            stall  = 1'b1;
            hcnt_d = need_n - 2'd1;
        end else if (mul_wait) begin
            stall  = 1'b1;
        end
        // Outputs must read as idle for the whole reset window, even if ID still shows a hazard.
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (!stall && MulDiv_ID) begin
            mcnt_d = LAT;
        end else if (mcnt_q != 4'd0) begin
            mcnt_d = mcnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= 2'd0;
            mcnt_q <= 4'd0;
        end else begin
            hcnt_q <= hcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    always_comb begin
        PCWr       = !stall;
        IFIDWr     = !stall;
        IDEx_Flush = stall;
        IFID_Flush = !stall && !reset && Taken_ID;
        MulDivBusy = !reset && (mcnt_q != 4'd0);
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed and randomized checks of hazard_stall_unit against a cycle model
module tb_hazard_stall_unit;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_reg, rt_reg, rw_IDEx, rw_ExMem;
    logic       UseRs_ID, UseRt_ID, Branch_ID, Taken_ID, MulDiv_ID, HiLoRd_ID;
    logic       RegWr_IDEx, MemRead_IDEx, MemRead_ExMem;
    logic       PCWr, IFIDWr, IDEx_Flush, IFID_Flush, MulDivBusy;

    int checks = 0;
    int errors = 0;

    // Reference state: stall cycles still owed to a data hazard, cycles until HI/LO valid.
    int owed_stalls = 0;
    int muldiv_left = 0;

    hazard_stall_unit #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .rs_reg(rs_reg), .rt_reg(rt_reg),
        .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID), .Branch_ID(Branch_ID), .Taken_ID(Taken_ID),
        .MulDiv_ID(MulDiv_ID), .HiLoRd_ID(HiLoRd_ID), .rw_IDEx(rw_IDEx), .RegWr_IDEx(RegWr_IDEx),
        .MemRead_IDEx(MemRead_IDEx), .rw_ExMem(rw_ExMem), .MemRead_ExMem(MemRead_ExMem),
        .PCWr(PCWr), .IFIDWr(IFIDWr), .IDEx_Flush(IDEx_Flush), .IFID_Flush(IFID_Flush),
        .MulDivBusy(MulDivBusy)
    );

    always #5 clk = ~clk;

    function automatic bit reads(input logic [4:0] r);
        return r != 0 && ((UseRs_ID && r == rs_reg) || (UseRt_ID && r == rt_reg));
    endfunction

    function automatic int fresh_hazard();
        bit in_ex  = RegWr_IDEx && reads(rw_IDEx);
        bit in_mem = MemRead_ExMem && reads(rw_ExMem);
        if (Branch_ID && in_ex && MemRead_IDEx) return 2;
        if (Branch_ID && (in_ex || in_mem)) return 1;
        if (!Branch_ID && in_ex && MemRead_IDEx) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        if (reset) return 0;
        if (owed_stalls > 0) return 1;
        if (fresh_hazard() > 0) return 1;
        return (MulDiv_ID || HiLoRd_ID) && muldiv_left > 0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        bit s = model_stall();
        chk({tag, ".PCWr"}, PCWr, !s);
        chk({tag, ".IFIDWr"}, IFIDWr, !s);
        chk({tag, ".IDEx_Flush"}, IDEx_Flush, s);
        chk({tag, ".IFID_Flush"}, IFID_Flush, !s && !reset && Taken_ID);
        chk({tag, ".MulDivBusy"}, MulDivBusy, !reset && muldiv_left > 0);
    endtask

    // Inputs are set just after a falling edge; sample, clock, advance the model.
    task automatic cyc(input string tag);
        bit s;
        int n;
        #1;
        chk_all(tag);
        s = model_stall();
        n = fresh_hazard();
        @(posedge clk);
        if (reset) begin
            owed_stalls = 0;
            muldiv_left = 0;
        end else begin
            owed_stalls = (owed_stalls > 0) ? owed_stalls - 1 : ((n > 0) ? n - 1 : 0);
            if (!s && MulDiv_ID) muldiv_left = LAT;
            else if (muldiv_left > 0) muldiv_left = muldiv_left - 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_reg = 0; rt_reg = 0; rw_IDEx = 0; rw_ExMem = 0;
        UseRs_ID = 0; UseRt_ID = 0; Branch_ID = 0; Taken_ID = 0;
        MulDiv_ID = 0; HiLoRd_ID = 0; RegWr_IDEx = 0; MemRead_IDEx = 0; MemRead_ExMem = 0;
    endtask

    task automatic ex_load(input logic [4:0] r);
        RegWr_IDEx = 1; MemRead_IDEx = 1; rw_IDEx = r;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        chk("rst.PCWr", PCWr, 1'b1);
        chk("rst.IDEx_Flush", IDEx_Flush, 1'b0);
        chk("rst.MulDivBusy", MulDivBusy, 1'b0);
        @(negedge clk);
        reset = 0;
        cyc("idle");

        // Load-use: one bubble, then proceed even though MEM still holds the load.
        ex_load(8); rs_reg = 8; UseRs_ID = 1;
        #1 chk("lu.stall", PCWr, 1'b0);
        cyc("lu0");
        idle_inputs(); rs_reg = 8; UseRs_ID = 1; MemRead_ExMem = 1; rw_ExMem = 8;
        #1 chk("lu.go", PCWr, 1'b1);
        cyc("lu1");

        // Branch on a just-loaded register: two stalls regardless of later EX/MEM contents.
        idle_inputs(); ex_load(9); rs_reg = 9; UseRs_ID = 1; Branch_ID = 1; Taken_ID = 1;
        cyc("br0");
        ex_load(0); RegWr_IDEx = 0; MemRead_ExMem = 1; rw_ExMem = 9;
        #1 chk("br1.stall", IDEx_Flush, 1'b1);
        chk("br1.taken_ignored", IFID_Flush, 1'b0);
        cyc("br1");
        MemRead_ExMem = 0; rw_ExMem = 0;
        #1 chk("br2.flush", IFID_Flush, 1'b1);
        cyc("br2");
        idle_inputs();
        cyc("br3");

        // $0 never creates a dependence; an unread operand never creates one either.
        ex_load(0); rs_reg = 0; UseRs_ID = 1;
        #1 chk("r0.nostall", PCWr, 1'b1);
        cyc("r0");
        ex_load(8); rs_reg = 3; rt_reg = 8; UseRt_ID = 0;
        #1 chk("unused_rt.nostall", PCWr, 1'b1);
        cyc("unused_rt");

        // mult followed by mflo: wait until the unit drains, then issue.
        idle_inputs(); MulDiv_ID = 1;
        cyc("mul.issue");
        MulDiv_ID = 0; HiLoRd_ID = 1;
        #1 chk("mflo.busy", MulDivBusy, 1'b1);
        for (int i = 0; i < 8; i++) cyc($sformatf("mflo%0d", i));
        #1 chk("mflo.issued", PCWr, 1'b1);
        idle_inputs();
        cyc("mflo.done");

        // Data hazard ahead of pending mfhi: two data stalls, one mul/div stall, issue.
        MulDiv_ID = 1;
        cyc("pri.mult");
        MulDiv_ID = 0;
        cyc("pri.gap");
        ex_load(9); rs_reg = 9; UseRs_ID = 1; Branch_ID = 1; HiLoRd_ID = 1;
        cyc("pri0");
        ex_load(0); RegWr_IDEx = 0;
        cyc("pri1");
        #1 chk("pri2.mulstall", PCWr, 1'b0);
        chk("pri2.busy", MulDivBusy, 1'b1);
        cyc("pri2");
        #1 chk("pri3.issue", PCWr, 1'b1);
        cyc("pri3");

        // Asynchronous reset inside the first of two branch stall cycles.
        idle_inputs(); ex_load(9); rs_reg = 9; UseRs_ID = 1; Branch_ID = 1; Taken_ID = 1;
        #1 chk("rstmid.pre", PCWr, 1'b0);
        #1 reset = 1;
        #1;
        chk("rstmid.PCWr", PCWr, 1'b1);
        chk("rstmid.IFIDWr", IFIDWr, 1'b1);
        chk("rstmid.IDEx_Flush", IDEx_Flush, 1'b0);
        chk("rstmid.IFID_Flush", IFID_Flush, 1'b0);
        chk("rstmid.MulDivBusy", MulDivBusy, 1'b0);
        owed_stalls = 0;
        muldiv_left = 0;
        @(negedge clk);
        idle_inputs();
        reset = 0;
        cyc("rstmid.post");

        // Random traffic on a small register set so matches are frequent.
        for (int i = 0; i < 500; i++) begin
            rs_reg = 5'($urandom_range(0, 3)); rt_reg = 5'($urandom_range(0, 3));
            rw_IDEx = 5'($urandom_range(0, 3)); rw_ExMem = 5'($urandom_range(0, 3));
            UseRs_ID = 1'($urandom); UseRt_ID = 1'($urandom);
            Branch_ID = ($urandom_range(0, 3) == 0); Taken_ID = 1'($urandom);
            MulDiv_ID = ($urandom_range(0, 7) == 0); HiLoRd_ID = ($urandom_range(0, 3) == 0);
            RegWr_IDEx = 1'($urandom); MemRead_IDEx = 1'($urandom); MemRead_ExMem = 1'($urandom);
            reset = ($urandom_range(0, 60) == 0);
            cyc($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
